// File: rtl/beat_detector.sv
// Hysteresis beat detector over a stream of SNR samples in dB.
// Emits one pulse per beat, holds off retriggering through a refractory window, and counts beats.
module beat_detector #(
  parameter int SNR_WIDTH   = 16,
  parameter int THRESH_ON   = 25,
  parameter int THRESH_OFF  = 20,
  parameter int REFRACTORY  = 4,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   snr_valid,
  input  logic [SNR_WIDTH-1:0]   snr_db,
  input  logic                   count_clear,
  output logic                   beat_pulse,
  output logic                   beat_active,
  output logic [COUNT_WIDTH-1:0] beat_count
);

  localparam int REFR_W = (REFRACTORY > 1) ? $clog2(REFRACTORY + 1) : 1;
  localparam logic [SNR_WIDTH-1:0]   ON_LEVEL  = SNR_WIDTH'(THRESH_ON);
  localparam logic [SNR_WIDTH-1:0]   OFF_LEVEL = SNR_WIDTH'(THRESH_OFF);
  localparam logic [REFR_W-1:0]      REFR_LOAD = REFR_W'(REFRACTORY);
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

  if (THRESH_OFF > THRESH_ON) begin : g_thresh_check
    $error("beat_detector: THRESH_OFF must not exceed THRESH_ON");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    REFRACT = 2'd2
  } state_t;

  state_t              state;
  logic [REFR_W-1:0]   refr_cnt;
  logic                beat_fire;

  // A beat is only recognised from IDLE; ACTIVE and REFRACT never retrigger.
  assign beat_fire = snr_valid && (state == IDLE) && (snr_db >= ON_LEVEL);

  // Detection FSM; pulse and active flag are registered alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      refr_cnt    <= '0;
      beat_pulse  <= 1'b0;
      beat_active <= 1'b0;
    end else begin
      beat_pulse <= 1'b0;
      if (snr_valid) begin
        case (state)
          IDLE: begin
            if (beat_fire) begin
              state       <= ACTIVE;
              beat_pulse  <= 1'b1;
              beat_active <= 1'b1;
            end
          end
          ACTIVE: begin
            if (snr_db < OFF_LEVEL) begin
              beat_active <= 1'b0;
              if (REFRACTORY == 0) begin
                state <= IDLE;
              end else begin
                state    <= REFRACT;
                refr_cnt <= REFR_LOAD;
              end
            end
          end
          REFRACT: begin
            // The sample that ends the window is consumed here, not evaluated as a trigger.
            refr_cnt <= refr_cnt - REFR_W'(1);
            if (refr_cnt <= REFR_W'(1)) begin
              state    <= IDLE;
              refr_cnt <= '0;
            end
          end
          default: begin
            state       <= IDLE;
            refr_cnt    <= '0;
            beat_active <= 1'b0;
          end
        endcase
      end
    end
  end

  // Saturating beat counter; a clear that lands on a beat leaves that beat counted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_count <= '0;
    end else if (count_clear) begin
      beat_count <= beat_fire ? COUNT_WIDTH'(1) : '0;
    end else if (beat_fire && (beat_count != COUNT_MAX)) begin
      beat_count <= beat_count + COUNT_WIDTH'(1);
    end
  end

endmodule

// File: doc/beat_detector.md
BEAT_DETECTOR -- requirements
Module: beat_detector

Interface
REQ-001 Parameter SNR_WIDTH, default 16, width of the unsigned SNR sample in dB.
REQ-002 Parameter THRESH_ON, default 25, rising threshold in dB (beat when sample >= THRESH_ON).
REQ-003 Parameter THRESH_OFF, default 20, falling threshold in dB (release when sample < THRESH_OFF); THRESH_OFF <= THRESH_ON SHALL hold, checked by elaboration assertion.
REQ-004 Parameter REFRACTORY, default 4, number of valid samples ignored after release; 0 permitted.
REQ-005 Parameter COUNT_WIDTH, default 16, width of the beat counter.
REQ-006 clk  input  1  single system clock; all state updates on its rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 snr_valid  input  1  qualifies snr_db for one cycle; samples with snr_valid=0 SHALL be ignored.
REQ-009 snr_db  input  SNR_WIDTH  unsigned SNR sample in dB.
REQ-010 count_clear  input  1  synchronous clear of beat_count.
REQ-011 beat_pulse  output  1  registered one-cycle pulse per detected beat.
REQ-012 beat_active  output  1  high while the state is ACTIVE.
REQ-013 beat_count  output  COUNT_WIDTH  number of beats since reset or the last clear.

Function
REQ-014 FSM states SHALL be IDLE, ACTIVE and REFRACT; all comparisons SHALL be unsigned at full SNR_WIDTH.
REQ-015 IDLE: a valid sample >= THRESH_ON SHALL move the FSM to ACTIVE and assert beat_pulse for exactly the next cycle (latency 1 clock from the sampling edge).
REQ-016 IDLE: a valid sample < THRESH_ON SHALL leave the FSM in IDLE with no pulse.
REQ-017 ACTIVE: a valid sample < THRESH_OFF SHALL go to REFRACT with the refractory counter loaded to REFRACTORY, or go directly to IDLE when REFRACTORY=0.
REQ-018 ACTIVE: samples >= THRESH_OFF, including samples >= THRESH_ON, SHALL hold ACTIVE with no further pulse (hysteresis, no retrigger).
REQ-019 REFRACT: each valid sample SHALL decrement the counter regardless of value; when a valid sample arrives with the counter at 1, the FSM SHALL go to IDLE.
REQ-020 The sample that ends REFRACT SHALL NOT be evaluated against THRESH_ON; only the next valid sample in IDLE can trigger.
REQ-021 beat_active SHALL be 1 exactly in ACTIVE and is registered together with the state.
REQ-022 beat_count SHALL increment in the same cycle beat_pulse is asserted and SHALL saturate at 2^COUNT_WIDTH-1 without wrapping.
REQ-023 count_clear alone SHALL set beat_count to 0 on the next edge; count_clear coinciding with a beat increment SHALL set beat_count to 1; count_clear SHALL NOT affect the FSM.
REQ-024 Gaps in snr_valid SHALL NOT advance the FSM, the refractory counter or beat_pulse generation; beat_pulse SHALL never exceed one cycle.

Reset
REQ-025 Asserting reset SHALL immediately force state IDLE, refractory counter 0, beat_pulse 0, beat_active 0 and beat_count 0, independent of clk.
REQ-026 Reset asserted mid-ACTIVE or mid-REFRACT SHALL abort the operation; after release the first valid sample >= THRESH_ON SHALL produce a pulse.

Verification
REQ-027 Defaults; valid samples 0, 24, 25 -> no pulse for 0 and 24; a single-cycle beat_pulse one clock after 25; beat_active=1; beat_count=1.
REQ-028 Hysteresis: 30, 22, 26, 19 -> one pulse only; beat_active stays 1 through 22 and 26; FSM enters REFRACT on 19.
REQ-029 Refractory: after release, valid samples 40, 40, 40, 40 (REFRACTORY=4) -> no pulse; the next valid 40 -> pulse; beat_count=2.
REQ-030 Valid gaps: 25 with snr_valid low for 10 cycles then high -> no trigger during the gap; trigger on the first valid cycle only.
REQ-031 Counter: COUNT_WIDTH=2, 5 beats -> beat_count saturates at 3; count_clear on the same cycle as a beat -> beat_count=1; count_clear alone -> 0.
REQ-032 Asynchronous reset asserted between edges while in REFRACT -> all outputs 0 immediately; after release, sample 0xFFFF -> pulse.
